// File: rtl/pkt_filter.sv
// pkt_filter: forwards VLAN-tagged UDP packets and discards all other packets.
// The decision is made once, on the first beat of each packet, from the
// Ethernet TPID and IP protocol fields. A single output register stage
// decouples the upstream ready from the downstream stream. Two saturating
// counters report how many packets were forwarded and how many were dropped.
module pkt_filter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              areset,
    // packet stream from the MAC side
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    // filtered stream towards the rmt_wrapper
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    // statistics
    output logic [31:0]                       pkt_pass_cnt,
    output logic [31:0]                       pkt_drop_cnt
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

    // IDLE waits for a first beat; PASS/DROP cover the remaining beats of a packet
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                            state_q,  state_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    tdata_q,  tdata_d;
    logic [KEEP_W-1:0]                 tkeep_q,  tkeep_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   tuser_q,  tuser_d;
    logic                              tlast_q,  tlast_d;
    logic                              tvalid_q, tvalid_d;
    logic [31:0]                       pass_cnt_q, pass_cnt_d;
    logic [31:0]                       drop_cnt_q, drop_cnt_d;

    logic s_xfer;
    logic hdr_match;
    logic fwd_beat;

    // The stage can take a beat when it is empty or being emptied this cycle;
    // reset forces ready low so nothing is consumed while the block is cleared.
    assign s_axis_tready = ~areset & (~tvalid_q | m_axis_tready);

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign pkt_pass_cnt  = pass_cnt_q;
    assign pkt_drop_cnt  = drop_cnt_q;

    // Filter decision, next FSM state, output stage loading and counter updates
    always_comb begin
        state_d    = state_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tuser_d    = tuser_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fwd_beat   = 1'b0;

        s_xfer    = s_axis_tvalid & s_axis_tready;
        // TPID 0x8100 appears byte-swapped in the little-endian tdata word
        hdr_match = (s_axis_tdata[111:96] == 16'h0081) && (s_axis_tdata[223:216] == 8'h11);

        case (state_q)
            IDLE: begin
                if (s_xfer) begin
                    if (hdr_match) begin
                        fwd_beat = 1'b1;
                        if (pass_cnt_q != 32'hFFFF_FFFF) begin
                            pass_cnt_d = pass_cnt_q + 32'd1;
                        end
                        if (!s_axis_tlast) begin
                            state_d = PASS;
                        end
                    end else begin
                        if (drop_cnt_q != 32'hFFFF_FFFF) begin
                            drop_cnt_d = drop_cnt_q + 32'd1;
                        end
                        if (!s_axis_tlast) begin
                            state_d = DROP;
                        end
                    end
                end
            end
            PASS: begin
                if (s_xfer) begin
                    fwd_beat = 1'b1;
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (s_xfer && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new forwarded beat overwrites the stage; otherwise a taken beat empties it.
        // While full and stalled, nothing is loaded because s_axis_tready is low.
        if (fwd_beat) begin
            tdata_d  = s_axis_tdata;
            tkeep_d  = s_axis_tkeep;
            tuser_d  = s_axis_tuser;
            tlast_d  = s_axis_tlast;
            tvalid_d = 1'b1;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // State, output stage and counter registers with asynchronous clear
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tuser_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_pkt_filter.sv
// tb_pkt_filter: directed scenarios plus randomized packets for pkt_filter.
// Reference model: a packet-level filter (decide on first beat, remember the
// decision until tlast) feeding a one-entry expected-output queue; counters
// are plain saturating integers.
module tb_pkt_filter;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 128;

    logic          clk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_valid;
    logic          s_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_ready;
    logic [31:0]   pkt_pass_cnt;
    logic [31:0]   pkt_drop_cnt;

    always #5 clk = ~clk;

    pkt_filter #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW)
    ) dut (
        .clk          (clk),
        .areset       (areset),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_valid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_ready),
        .pkt_pass_cnt (pkt_pass_cnt),
        .pkt_drop_cnt (pkt_drop_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t  sb[$];        // beats expected on m_axis, oldest first
    beat_t  pkt[4];       // packet being sent
    int     n_pass  = 0;
    int     n_total = 0;
    longint exp_pass = 0;
    longint exp_drop = 0;
    bit     mid_pkt  = 1'b0;
    bit     pkt_keep = 1'b0;
    bit     rdy_rand = 1'b0;
    bit     gaps     = 1'b0;
    int     stall_cnt = 0;
    bit     last_in_xfer = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [KW-1:0] rnd_keep();
        logic [KW-1:0] r;
        r = {$urandom, $urandom};
        return r;
    endfunction

    function automatic logic [UW-1:0] rnd_user();
        logic [UW-1:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic bit accepts(input logic [DW-1:0] d);
        return (d[111:96] == 16'h0081) && (d[223:216] == 8'h11);
    endfunction

    function automatic longint sat_inc(input longint c);
        return (c >= 64'hFFFF_FFFF) ? c : c + 1;
    endfunction

    // kind: 0 = VLAN+UDP, 1 = wrong TPID, 2 = TCP
    task automatic build_pkt(input int len, input int kind);
        for (int b = 0; b < 4; b++) begin
            pkt[b].d = rnd_data();
            pkt[b].k = rnd_keep();
            pkt[b].u = rnd_user();
            pkt[b].l = (b == len - 1);
        end
        pkt[0].d[111:96]  = (kind == 1) ? 16'h0008 : 16'h0081;
        pkt[0].d[223:216] = (kind == 2) ? 8'h06 : 8'h11;
    endtask

    task automatic model_reset();
        sb.delete();
        mid_pkt  = 1'b0;
        pkt_keep = 1'b0;
        exp_pass = 0;
        exp_drop = 0;
    endtask

    // One clock cycle: called at a falling edge with s_* already driven
    task automatic step();
        beat_t cur;
        bit    in_xfer;
        bit    exp_rdy;
        if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
        else          m_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        #1;
        exp_rdy = (sb.size() == 0) || m_ready;
        chk("s_tready", DW'(s_axis_tready), DW'(exp_rdy));
        in_xfer = s_valid && exp_rdy;
        if (sb.size() != 0 && m_ready) void'(sb.pop_front());
        if (in_xfer) begin
            if (!mid_pkt) begin
                pkt_keep = accepts(s_tdata);
                if (pkt_keep) exp_pass = sat_inc(exp_pass);
                else          exp_drop = sat_inc(exp_drop);
            end
            mid_pkt = !s_tlast;
            if (pkt_keep) begin
                cur.d = s_tdata; cur.k = s_tkeep; cur.u = s_tuser; cur.l = s_tlast;
                sb.push_back(cur);
            end
        end
        last_in_xfer = in_xfer;
        @(posedge clk);
        @(negedge clk);
        chk("m_tvalid", DW'(m_axis_tvalid), DW'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("m_tdata", m_axis_tdata, sb[0].d);
            chk("m_tkeep", DW'(m_axis_tkeep), DW'(sb[0].k));
            chk("m_tuser", DW'(m_axis_tuser), DW'(sb[0].u));
            chk("m_tlast", DW'(m_axis_tlast), DW'(sb[0].l));
        end
        chk("pass_cnt", DW'(pkt_pass_cnt), DW'(exp_pass));
        chk("drop_cnt", DW'(pkt_drop_cnt), DW'(exp_drop));
    endtask

    // Send beats [from..to] of pkt[], holding each until it is taken
    task automatic send_beats(input int from, input int to, input int stall_beat);
        int cnt;
        for (int b = from; b <= to; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    s_tdata = rnd_data();
                    s_tlast = 1'($urandom_range(0, 1));
                    step();
                end
            end
            if (b == stall_beat) stall_cnt = 3;
            s_valid = 1'b1;
            s_tdata = pkt[b].d;
            s_tkeep = pkt[b].k;
            s_tuser = pkt[b].u;
            s_tlast = pkt[b].l;
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (!last_in_xfer && cnt < 200);
            if (!last_in_xfer) begin
                n_total++;
                $display("FAIL xfer_timeout: beat %0d not taken after %0d cycles, required within 200", b, cnt);
                $display("%0d/%0d checks passed", n_pass, n_total);
                $fatal(1, "input transfer timeout");
            end
        end
        s_valid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int kind, input int stall_beat);
        build_pkt(len, kind);
        send_beats(0, len - 1, stall_beat);
    endtask

    // Assert reset at a falling edge, check the cleared state, release two edges later
    task automatic pulse_reset();
        areset = 1'b1;
        model_reset();
        #1;
        chk("rst_tvalid", DW'(m_axis_tvalid), '0);
        chk("rst_tlast",  DW'(m_axis_tlast), '0);
        chk("rst_tdata",  m_axis_tdata, '0);
        chk("rst_tkeep",  DW'(m_axis_tkeep), '0);
        chk("rst_tuser",  DW'(m_axis_tuser), '0);
        chk("rst_tready", DW'(s_axis_tready), '0);
        chk("rst_pass",   DW'(pkt_pass_cnt), '0);
        chk("rst_drop",   DW'(pkt_drop_cnt), '0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_tready", DW'(s_axis_tready), '0);
        areset = 1'b0;
    endtask

    initial begin
        areset  = 1'b1;
        s_valid = 1'b0;
        s_tlast = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tuser = '0;
        m_ready = 1'b1;
        @(negedge clk);
        pulse_reset();

        // 4-beat accepted packet, full downstream ready
        send_pkt(4, 0, -1);
        repeat (2) step();
        chk("pass_after_good", DW'(pkt_pass_cnt), DW'(64'd1));

        // rejected 4-beat TCP packet, then an accepted one
        send_pkt(4, 2, -1);
        repeat (2) step();
        chk("drop_after_tcp", DW'(pkt_drop_cnt), DW'(64'd1));
        send_pkt(4, 0, -1);
        repeat (2) step();

        // downstream stall of 3 cycles while beat 2 sits in the output stage
        send_pkt(4, 0, 2);
        repeat (2) step();

        // back-to-back single-beat packets: accepted, rejected, accepted
        send_pkt(1, 0, -1);
        send_pkt(1, 1, -1);
        send_pkt(1, 0, -1);
        repeat (2) step();

        // randomized traffic with input gaps and random downstream ready
        rdy_rand = 1'b1;
        gaps     = 1'b1;
        for (int p = 0; p < 80; p++) begin
            send_pkt($urandom_range(1, 4), $urandom_range(0, 2), -1);
        end
        rdy_rand = 1'b0;
        gaps     = 1'b0;
        repeat (3) step();

        // reset after beat 2 of an accepted packet; remaining beats form a rejected packet
        build_pkt(4, 0);
        pkt[2].d[111:96] = 16'h0800;
        send_beats(0, 1, -1);
        pulse_reset();
        send_beats(2, 3, -1);
        repeat (2) step();
        chk("drop_after_rst", DW'(pkt_drop_cnt), DW'(64'd1));
        chk("pass_after_rst", DW'(pkt_pass_cnt), DW'(64'd0));

        // pass counter saturation
        force dut.pass_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.pass_cnt_q;
        exp_pass = 64'hFFFF_FFFE;
        for (int p = 0; p < 3; p++) send_pkt(2, 0, -1);
        repeat (2) step();
        chk("pass_saturated", DW'(pkt_pass_cnt), DW'(32'hFFFF_FFFF));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pkt_filter.md
PKT_FILTER -- requirements
Module: pkt_filter

Interface
REQ-001 C_S_AXIS_DATA_WIDTH, 512, tdata width of both AXI-Stream ports; tkeep width is C_S_AXIS_DATA_WIDTH/8.
REQ-002 C_S_AXIS_TUSER_WIDTH, 128, tuser width of both AXI-Stream ports.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 areset  input  1  reset, asynchronous, active-high.
REQ-005 s_axis_tdata/tkeep/tuser/tvalid/tlast  input  512/64/128/1/1  packet stream from the MAC side.
REQ-006 s_axis_tready  output  1  upstream backpressure.
REQ-007 m_axis_tdata/tkeep/tuser/tvalid/tlast  output  512/64/128/1/1  filtered stream to the rmt_wrapper slave port.
REQ-008 m_axis_tready  input  1  downstream backpressure.
REQ-009 pkt_pass_cnt  output  32  count of packets forwarded.
REQ-010 pkt_drop_cnt  output  32  count of packets discarded.

Function
REQ-011 A beat transfers on an input port when tvalid and tready are both 1 in the same cycle.
REQ-012 Byte 0 of the wire is tdata[7:0]; the first beat is the first transfer after reset or after a beat with tlast=1.
REQ-013 A packet is accepted when its first beat has tdata[111:96]==16'h0081 (VLAN TPID 0x8100) and tdata[223:216]==8'h11 (UDP); any other packet is dropped.
REQ-014 FSM states: IDLE (awaiting first beat), PASS (forwarding), DROP (discarding); reset state IDLE.
REQ-015 IDLE: an accepted first beat with tlast=0 moves to PASS; a rejected first beat with tlast=0 moves to DROP; a first beat with tlast=1 stays in IDLE after being forwarded or dropped.
REQ-016 PASS/DROP: a transferred beat with tlast=1 returns to IDLE; all other beats hold the state.
REQ-017 Output is a single register stage: forwarded beats appear on m_axis_* exactly 1 cycle after the input transfer when the stage is empty.
REQ-018 s_axis_tready = (~m_axis_tvalid | m_axis_tready) when not in reset; 0 while areset=1.
REQ-019 Output register loads tdata/tkeep/tuser/tlast unmodified and sets m_axis_tvalid=1 for forwarded beats; on m_axis_tready=1 with no new forwarded beat, m_axis_tvalid goes to 0.
REQ-020 m_axis_* signals hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 Dropped beats are consumed (tready per REQ-018) and never raise m_axis_tvalid.
REQ-022 pkt_pass_cnt increments by 1 on transfer of an accepted first beat; pkt_drop_cnt increments by 1 on transfer of a rejected first beat.
REQ-023 Both counters saturate at 32'hFFFFFFFF and do not wrap.
REQ-024 Input tvalid deasserted mid-packet (gaps) does not change state or counters.
REQ-025 tkeep and tuser are not examined for the filter decision.

Reset
REQ-026 areset=1 asynchronously forces: FSM IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0, s_axis_tready=0, both counters 0.
REQ-027 Reset asserted mid-packet abandons the packet; after release the next transferred beat is treated as a first beat.
REQ-028 First transfer may occur on the first rising edge after areset falls.

Verification
REQ-029 4-beat packet, beat 0 with tdata[111:96]=16'h0081, tdata[223:216]=8'h11, m_axis_tready=1 -> 4 beats on m_axis, each 1 cycle after input, identical data, tlast on beat 4, pkt_pass_cnt=1.
REQ-030 4-beat packet with tdata[223:216]=8'h06 -> m_axis_tvalid stays 0, s_axis_tready=1 throughout, pkt_drop_cnt=1; following accepted packet forwards normally.
REQ-031 Accepted packet with m_axis_tready=0 for 3 cycles during beat 2 -> s_axis_tready=0 during stall, m_axis_* held stable, no beat lost or duplicated.
REQ-032 Single-beat packets back-to-back: accepted, rejected, accepted (tlast=1 each) -> beats 1 and 3 forwarded, counters pass=2 drop=1, FSM IDLE after each.
REQ-033 areset pulsed after beat 2 of an accepted 4-beat packet -> outputs and counters 0 immediately; next beat (former beat 3, lacking TPID) treated as first beat and dropped, pkt_drop_cnt=1.
REQ-034 Force pkt_pass_cnt to 32'hFFFFFFFE, send 3 accepted packets -> count reads 32'hFFFFFFFF and stays there.
